// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Round-robin time-sharing of one combinational ALU between two
//            requesters; latch operands, execute one cycle, return result.
// Revision : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [OPW-1:0]   op0,
  input  logic [OPW-1:0]   op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_winner;
  logic             r_last;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             w_pick;
  logic             w_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    done0       = 1'b0;
    done1       = 1'b0;
    busy        = 1'b0;
    w_start     = 1'b0;
    // A lone requester always wins; on a tie the one not served last wins.
    w_pick      = ~r_last;
    if (req0 && !req1) begin
      w_pick = 1'b0;
    end else if (!req0 && req1) begin
      w_pick = 1'b1;
    end
    case (r_state)
      ST_IDLE: begin
        if (req0 || req1) begin
          w_start     = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        gnt0        = ~r_winner;
        gnt1        = r_winner;
        busy        = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done0       = ~r_winner;
        done1       = r_winner;
        busy        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_winner <= 1'b0;
      r_last   <= 1'b1;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      // Operands are frozen here so requester changes during EXEC are ignored.
      if (w_start) begin
        r_winner <= w_pick;
        r_op     <= w_pick ? op1 : op0;
        r_a      <= w_pick ? a1  : a0;
        r_b      <= w_pick ? b1  : b0;
      end
      if (r_state == ST_EXEC) begin
        r_result <= alu_result;
        r_zero   <= alu_zero;
      end
      if (r_state == ST_DONE) begin
        r_last <= r_winner;
      end
    end
  end

  assign alu_op = r_op;
  assign alu_a  = r_a;
  assign alu_b  = r_b;
  assign result = r_result;
  assign zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Directed, table-driven bench for alu_share_arbiter with a
//            behavioural ALU attached to the shared-ALU ports.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 3;

  localparam logic [OPW-1:0] C_AND = 3'd0;
  localparam logic [OPW-1:0] C_OR  = 3'd1;
  localparam logic [OPW-1:0] C_ADD = 3'd2;
  localparam logic [OPW-1:0] C_SUB = 3'd3;
  localparam logic [OPW-1:0] C_SLT = 3'd4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1;
  logic [OPW-1:0]   op0, op1;
  logic [WIDTH-1:0] a0, a1, b0, b1;
  logic             gnt0, gnt1, done0, done1, zero, busy;
  logic [WIDTH-1:0] result;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  int n_checks = 0;
  int n_pass   = 0;

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .zero(zero), .busy(busy),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Behavioural shared ALU
  always_comb begin
    alu_result = '0;
    case (alu_op)
      C_AND:   alu_result = alu_a & alu_b;
      C_OR:    alu_result = alu_a | alu_b;
      C_ADD:   alu_result = alu_a + alu_b;
      C_SUB:   alu_result = alu_a - alu_b;
      C_SLT:   alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    logic             who;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             z;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.who) begin
      req1 = 1'b1; op1 = v.op; a1 = v.a; b1 = v.b;
    end else begin
      req0 = 1'b1; op0 = v.op; a0 = v.a; b0 = v.b;
    end
    tick();
    chk("vec_gnt0", {31'd0, gnt0}, {31'd0, ~v.who});
    chk("vec_gnt1", {31'd0, gnt1}, {31'd0, v.who});
    chk("vec_exec_done", {30'd0, done1, done0}, 32'd0);
    chk("vec_exec_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("vec_done0", {31'd0, done0}, {31'd0, ~v.who});
    chk("vec_done1", {31'd0, done1}, {31'd0, v.who});
    chk("vec_done_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("vec_result", result, v.res);
    chk("vec_zero", {31'd0, zero}, {31'd0, v.z});
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("vec_idle_busy", {31'd0, busy}, 32'd0);
    chk("vec_result_hold", result, v.res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, C_OR,  32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b0};
    vecs[1] = '{1'b1, C_SUB, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1};
    vecs[2] = '{1'b0, C_OR,  32'h00000001, 32'h00000000, 32'h00000001, 1'b0};
    vecs[3] = '{1'b1, C_AND, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0};
    vecs[4] = '{1'b0, C_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[5] = '{1'b1, C_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[6] = '{1'b0, C_SLT, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1};
    vecs[7] = '{1'b1, C_ADD, 32'h00000007, 32'h00000008, 32'h0000000F, 1'b0};

    op0 = '0; op1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst_gnt_done", {28'd0, gnt0, gnt1, done0, done1}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Tie right after reset: requester 0 first, then requester 1
    do_reset();
    req0 = 1'b1; op0 = C_OR;  a0 = 32'hF0F00000; b0 = 32'h00000F0F;
    req1 = 1'b1; op1 = C_ADD; a1 = 32'h00000100; b1 = 32'h00000023;
    tick();
    chk("tie_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
    tick();
    chk("tie_done0", {30'd0, done1, done0}, 32'd1);
    chk("tie_result0", result, 32'hF0F00F0F);
    req0 = 1'b0;
    tick();
    chk("tie_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("tie_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
    chk("tie_alu_a1", alu_a, 32'h00000100);
    tick();
    chk("tie_done1", {30'd0, done1, done0}, 32'd2);
    chk("tie_result1", result, 32'h00000123);
    req1 = 1'b0;
    tick();

    // Fairness: both held high, grants must alternate 0,1,0,1
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    op0 = C_AND; op1 = C_OR;
    for (int k = 1; k <= 12; k++) begin
      int phase;
      logic who;
      logic [3:0] exp;
      tick();
      phase = (k - 1) % 3;
      who   = logic'(((k - 1) / 3) % 2);
      exp   = 4'd0;
      if (phase == 0) exp = who ? 4'b0010 : 4'b0001;
      if (phase == 1) exp = who ? 4'b1000 : 4'b0100;
      chk($sformatf("fair_c%0d", k), {28'd0, done1, done0, gnt1, gnt0},
          {28'd0, exp});
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    tick();

    // Operand isolation: a0 changed during EXEC must not reach the ALU
    req0 = 1'b1; op0 = C_ADD; a0 = 32'd10; b0 = 32'd20;
    tick();
    a0 = 32'd1000;
    #1;
    chk("iso_alu_a", alu_a, 32'd10);
    tick();
    chk("iso_result", result, 32'd30);
    req0 = 1'b0;
    tick();

    // Reset asserted during EXEC aborts the operation
    req1 = 1'b1; op1 = C_OR; a1 = 32'h0000AAAA; b1 = 32'h00005555;
    tick();
    chk("abort_gnt1", {31'd0, gnt1}, 32'd1);
    reset = 1'b1; req1 = 1'b0;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {30'd0, done1, done0}, 32'd0);
    chk("abort_result", result, 32'd0);
    tick();
    chk("abort_no_done", {30'd0, done1, done0}, 32'd0);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
